spi_frame_seq: RTL and testbench
================================

SPI_FRAME_SEQ -- requirements
Module: spi_frame_seq

Interface
REQ-001 Parameter SEND_LEN, default 12: number of bytes transmitted per frame.
REQ-002 Parameter RECV_LEN, default 8: number of bytes collected per frame.
REQ-003 Parameter EN_WAIT_CYCLES, default 100: button stable-time (cycles) required to register a press or release.
REQ-004 Parameter PATTERN_BASE, default 8'hA0: value of the first transmitted byte.
REQ-005 clk  input  1  system clock, single clock domain, all flops on posedge.
REQ-006 rst  input  1  reset; asynchronous, active-high.
REQ-007 btn  input  1  raw push-button, asynchronous to clk.
REQ-008 tx_data  output  8  byte offered to the downstream SPI master.
REQ-009 tx_valid  output  1  tx_data is valid.
REQ-010 tx_ready  input  1  SPI master accepts tx_data this cycle.
REQ-011 rx_data  input  8  byte received by the SPI master.
REQ-012 rx_valid  input  1  single-cycle strobe; rx_data is valid.
REQ-013 frame_en  output  1  high for the whole frame; the master drives ss low while high.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 done  output  1  single-cycle pulse on frame completion.
REQ-016 led  output  16  {last received byte, XOR of all received bytes in the frame}.

Function
REQ-017 btn SHALL pass through a 2-flop synchronizer before any use.
- Debounce: a counter runs while the synchronized btn differs from the debounced level.
- The counter clears whenever the two match.
- The debounced level flips after EN_WAIT_CYCLES consecutive differing cycles.
REQ-018 A 0->1 flip of the debounced level SHALL produce one trigger pulse; holding the button SHALL NOT retrigger.
REQ-019 FSM states SHALL be IDLE, SEND, RECV, DONE.
- IDLE->SEND on trigger.
- SEND->RECV on the SEND_LEN-th accepted byte.
- RECV->DONE on the RECV_LEN-th rx_valid.
- DONE->IDLE unconditionally after 1 cycle.
REQ-020 A trigger in any state except IDLE SHALL be discarded, not queued.
REQ-021 SEND behaviour:
- tx_valid=1.
- tx_data = PATTERN_BASE + tx_idx, modulo 256.
- tx_idx increments only on the cycle tx_valid && tx_ready.
- tx_data SHALL hold stable while tx_ready=0.
REQ-022 tx_valid SHALL deassert in the cycle after the last handshake; no extra byte is offered.
REQ-023 rx_valid outside RECV SHALL be ignored: no count change, no led change.
REQ-024 On each rx_valid in RECV:
- led[15:8] <= rx_data.
- led[7:0] <= led[7:0] ^ rx_data.
- led[7:0] is cleared to 0 on the IDLE->SEND transition.
REQ-025 frame_en SHALL be 1 in SEND and RECV, and 0 in IDLE and DONE.
REQ-026 done SHALL be 1 exactly in DONE.
REQ-027 Index and count widths SHALL be $clog2(LEN+1); both counters clear on entry to SEND.
REQ-028 Latency budget:
- trigger->tx_valid: 1 cycle.
- last rx_valid->done: 1 cycle.
- btn edge->trigger: 2 + EN_WAIT_CYCLES cycles.

Reset
REQ-029 While rst=1, outputs SHALL hold:
- state=IDLE.
- tx_valid=0, tx_data=0.
- frame_en=0, busy=0, done=0.
- led=16'h0000.
REQ-030 While rst=1, internal state SHALL hold: debounced level 0, counters 0.
REQ-031 rst asserted mid-frame SHALL abort immediately, asynchronously, with no done pulse.
REQ-032 After release the block SHALL need a fresh debounced press to start a frame; a button held through reset yields one trigger.

Verification
REQ-033 Debounce: btn pulse of 50 cycles -> no trigger; btn held 150 cycles -> exactly one trigger, tx_valid high at cycle 103 after the edge.
REQ-034 Full frame, tx_ready=1 always:
- tx_data sequence 0xA0..0xAB, then rx 0x01..0x08.
- led=16'h0808 (last byte 0x08, XOR 0x08).
- done pulses once; frame_en spans SEND+RECV.
REQ-035 Back-pressure: tx_ready low for 5 cycles on byte 3 -> tx_data stays 0xA3, still 12 handshakes total.
REQ-036 Ignored inputs:
- rx_valid during SEND and IDLE -> led and count unchanged.
- second press during RECV -> no second frame.
REQ-037 Reset mid-frame at byte 6 of SEND:
- All outputs return to reset values the same cycle.
- Re-press -> frame restarts at 0xA0.
REQ-038 Wrap: PATTERN_BASE=8'hFA, SEND_LEN=12 -> tx_data 0xFA..0xFF, then 0x00..0x05.

Source files
------------

// File: rtl/spi_frame_seq.sv
// spi_frame_seq: debounced button starts one SPI frame that sends a fixed
// incrementing byte pattern, then collects reply bytes into a led summary.
module spi_frame_seq #(
    parameter int unsigned SEND_LEN       = 12,
    parameter int unsigned RECV_LEN       = 8,
    parameter int unsigned EN_WAIT_CYCLES = 100,
    parameter logic [7:0]  PATTERN_BASE   = 8'hA0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        frame_en,
    output logic        busy,
    output logic        done,
    output logic [15:0] led
);
    localparam int TW = $clog2(SEND_LEN + 1);
    localparam int RW = $clog2(RECV_LEN + 1);
    localparam int DW = $clog2(EN_WAIT_CYCLES + 1);
    localparam logic [TW-1:0] TX_LAST = TW'(SEND_LEN - 1);
    localparam logic [RW-1:0] RX_LAST = RW'(RECV_LEN - 1);
    localparam logic [DW-1:0] DB_LAST = DW'(EN_WAIT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SEND, RECV, DONE} state_t;

    state_t        r_state;
    state_t        w_next;
    logic          r_sync1;
    logic          r_sync2;
    logic          r_db;
    logic          r_db_prev;
    logic [DW-1:0] r_db_cnt;
    logic [TW-1:0] r_tx_idx;
    logic [RW-1:0] r_rx_cnt;
    logic [7:0]    r_led_last;
    logic [7:0]    r_led_xor;
    logic          w_trig;
    logic          w_start;
    logic          w_tx_fire;
    logic          w_rx_fire;
    logic [7:0]    w_tx_byte;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= btn;
            r_sync2 <= r_sync1;
        end
    end

    // Level flips only after the input has disagreed for the full window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_db      <= 1'b0;
            r_db_prev <= 1'b0;
            r_db_cnt  <= '0;
        end else begin
            r_db_prev <= r_db;
            if (r_sync2 == r_db) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == DB_LAST) begin
                r_db     <= ~r_db;
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + DW'(1);
            end
        end
    end

    assign w_trig    = r_db & ~r_db_prev;
    assign w_tx_byte = PATTERN_BASE + 8'(r_tx_idx);
    assign led       = {r_led_last, r_led_xor};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_start   = 1'b0;
        w_tx_fire = 1'b0;
        w_rx_fire = 1'b0;
        tx_valid  = 1'b0;
        tx_data   = 8'h00;
        frame_en  = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        unique case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (w_trig) begin
                    w_next  = SEND;
                    w_start = 1'b1;
                end
            end
            SEND: begin
                tx_valid  = 1'b1;
                tx_data   = w_tx_byte;
                frame_en  = 1'b1;
                w_tx_fire = tx_ready;
                if (tx_ready && r_tx_idx == TX_LAST) begin
                    w_next = RECV;
                end
            end
            RECV: begin
                frame_en  = 1'b1;
                w_rx_fire = rx_valid;
                if (rx_valid && r_rx_cnt == RX_LAST) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                done   = 1'b1;
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // The last-byte half of led survives into the next frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_idx   <= '0;
            r_rx_cnt   <= '0;
            r_led_last <= 8'h00;
            r_led_xor  <= 8'h00;
        end else begin
            if (w_start) begin
                r_tx_idx  <= '0;
                r_rx_cnt  <= '0;
                r_led_xor <= 8'h00;
            end
            if (w_tx_fire) begin
                r_tx_idx <= r_tx_idx + TW'(1);
            end
            if (w_rx_fire) begin
                r_rx_cnt   <= r_rx_cnt + RW'(1);
                r_led_last <= rx_data;
                r_led_xor  <= r_led_xor ^ rx_data;
            end
        end
    end

endmodule

// File: tb/tb_spi_frame_seq.sv
// Bench for spi_frame_seq: directed sequence with random handshakes and
// reply bytes, checked against a byte-level frame model.
module tb_spi_frame_seq;
    localparam int SL = 12;
    localparam int RL = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        btn = 1'b0;
    logic        tx_ready = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic [7:0]  tx_data, tx_data_w;
    logic        tx_valid, tx_valid_w;
    logic        frame_en, frame_en_w;
    logic        busy, busy_w;
    logic        done, done_w;
    logic [15:0] led, led_w;

    int total = 0;
    int bad = 0;
    logic [7:0] m_last = 8'h00;
    logic [7:0] m_xor = 8'h00;

    always #5 clk = ~clk;

    spi_frame_seq dut (
        .clk(clk), .rst(rst), .btn(btn),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .frame_en(frame_en), .busy(busy), .done(done), .led(led)
    );

    spi_frame_seq #(.PATTERN_BASE(8'hFA)) dut_w (
        .clk(clk), .rst(rst), .btn(btn),
        .tx_data(tx_data_w), .tx_valid(tx_valid_w), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .frame_en(frame_en_w), .busy(busy_w), .done(done_w), .led(led_w)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_txv"}, {31'd0, tx_valid}, 0);
        chk({tag, "_txd"}, {24'd0, tx_data}, 0);
        chk({tag, "_fen"}, {31'd0, frame_en}, 0);
        chk({tag, "_busy"}, {31'd0, busy}, 0);
        chk({tag, "_done"}, {31'd0, done}, 0);
        chk({tag, "_led"}, {16'd0, led}, 0);
    endtask

    task automatic wait_tx(input string tag, input int want);
        int n = 0;
        while (tx_valid !== 1'b1 && n < 400) begin
            step();
            n++;
        end
        chk(tag, n, want);
        chk({tag, "_w"}, {31'd0, tx_valid_w}, 1);
    endtask

    task automatic idle_watch(input string tag, input int cycles);
        int seen = 0;
        for (int i = 0; i < cycles; i++) begin
            rx_valid = 1'($urandom_range(0, 1));
            rx_data  = 8'($urandom);
            step();
            if (busy !== 1'b0 || busy_w !== 1'b0) seen++;
        end
        rx_valid = 1'b0;
        chk({tag, "_busy"}, seen, 0);
        chk({tag, "_led"}, {16'd0, led}, {16'd0, m_last, m_xor});
    endtask

    // mode 0: always ready, rx 1..8; 1: stall on byte 3; 2: random + press
    task automatic run_frame(input int mode);
        int sent = 0;
        int guard = 0;
        int stall = 0;
        int gap;
        m_xor = 8'h00;
        while (sent < SL && guard < 500) begin
            chk("tx_valid", {31'd0, tx_valid}, 1);
            chk("tx_data", {24'd0, tx_data}, {24'd0, 8'(8'hA0 + sent)});
            chk("tx_data_wrap", {24'd0, tx_data_w}, {24'd0, 8'(8'hFA + sent)});
            chk("led_send", {16'd0, led}, {16'd0, m_last, m_xor});
            rx_valid = 1'b0;
            if (mode == 1 && sent == 3 && stall < 5) begin
                tx_ready = 1'b0;
                stall++;
            end else if (mode == 2) begin
                tx_ready = 1'($urandom_range(0, 1));
                rx_valid = 1'($urandom_range(0, 1));
                rx_data  = 8'($urandom);
            end else begin
                tx_ready = 1'b1;
            end
            step();
            guard++;
            if (tx_ready) sent++;
        end
        rx_valid = 1'b0;
        tx_ready = 1'b1;
        chk("hs_count", sent, SL);
        if (mode == 1) chk("stall_cycles", stall, 5);
        chk("tx_valid_after", {31'd0, tx_valid}, 0);
        chk("fen_recv", {31'd0, frame_en}, 1);
        for (int i = 0; i < RL; i++) begin
            gap = (mode == 2) ? 40 : (mode == 1 ? $urandom_range(0, 2) : 0);
            if (mode == 2 && i == 4) btn = 1'b1;
            for (int g = 0; g < gap; g++) step();
            chk("fen_rx", {31'd0, frame_en}, 1);
            rx_valid = 1'b1;
            rx_data  = (mode == 0) ? 8'(i + 1) : 8'($urandom);
            m_last   = rx_data;
            m_xor    = m_xor ^ rx_data;
            step();
            rx_valid = 1'b0;
            if (i < RL - 1) chk("done_early", {31'd0, done}, 0);
        end
        chk("done", {31'd0, done}, 1);
        chk("done_w", {31'd0, done_w}, 1);
        chk("fen_done", {31'd0, frame_en}, 0);
        chk("busy_done", {31'd0, busy}, 1);
        chk("led", {16'd0, led}, {16'd0, m_last, m_xor});
        chk("led_w", {16'd0, led_w}, {16'd0, m_last, m_xor});
        if (mode == 0) chk("led_0808", {16'd0, led}, 32'h0808);
        step();
        chk("done_once", {31'd0, done}, 0);
        chk("busy_idle", {31'd0, busy}, 0);
    endtask

    initial begin
        repeat (3) step();
        chk_reset_vals("reset");
        rst = 1'b0;
        step();
        idle_watch("idle_rx", 20);

        btn = 1'b1;
        repeat (50) step();
        btn = 1'b0;
        idle_watch("short_pulse", 200);

        btn = 1'b1;
        wait_tx("lat_full", 103);
        run_frame(0);
        idle_watch("held", 30);
        btn = 1'b0;
        idle_watch("release", 150);

        btn = 1'b1;
        wait_tx("lat_bp", 103);
        btn = 1'b0;
        run_frame(1);
        idle_watch("after_bp", 150);

        btn = 1'b1;
        wait_tx("lat_rand", 103);
        btn = 1'b0;
        run_frame(2);
        btn = 1'b0;
        idle_watch("press_in_recv", 300);

        btn = 1'b1;
        wait_tx("lat_abort", 103);
        tx_ready = 1'b1;
        repeat (6) step();
        chk("byte6", {24'd0, tx_data}, 32'hA6);
        #2;
        rst = 1'b1;
        m_last = 8'h00;
        m_xor  = 8'h00;
        #1;
        chk_reset_vals("abort");
        repeat (3) step();
        chk("abort_done", {31'd0, done | done_w}, 0);
        rst = 1'b0;
        wait_tx("lat_rearm", 103);
        run_frame(0);
        btn = 1'b0;
        idle_watch("after_rearm", 150);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
